// File: rtl/count_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : count_scheduler_pkg
// Brief   : Shared types and constants for the mod-5 count scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package count_scheduler_pkg;

    localparam int MAX_VAL = 4;
    localparam int STEP_W  = 4;
    localparam int CNT_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Out-of-range start values saturate to the top of the counter range.
    function automatic logic [CNT_W-1:0] clamp_val(input logic [CNT_W-1:0] v);
        return (v > CNT_W'(MAX_VAL)) ? CNT_W'(MAX_VAL) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/count_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : count_scheduler_if
// Brief   : Request/grant/result bundle between requesters and the scheduler.
// Revision: 1.0 - initial release
// ============================================================================
interface count_scheduler_if;

    logic [1:0]                             req;
    logic [1:0]                             dir;
    logic [count_scheduler_pkg::CNT_W-1:0]  start0;
    logic [count_scheduler_pkg::CNT_W-1:0]  start1;
    logic [count_scheduler_pkg::STEP_W-1:0] steps0;
    logic [count_scheduler_pkg::STEP_W-1:0] steps1;
    logic [1:0]                             gnt;
    logic                                   busy;
    logic [1:0]                             done;
    logic [count_scheduler_pkg::CNT_W-1:0]  result;
    logic [count_scheduler_pkg::CNT_W-1:0]  y;

    modport master (
        output req, dir, start0, start1, steps0, steps1,
        input  gnt, busy, done, result, y
    );

    modport slave (
        input  req, dir, start0, start1, steps0, steps1,
        output gnt, busy, done, result, y
    );

endinterface
`default_nettype wire

// File: rtl/count_scheduler_step_counter.sv
`default_nettype none
// ============================================================================
// Module  : step_counter
// Brief   : Loadable mod-5 up/down counter with wrap and start-value clamp.
// Revision: 1.0 - initial release
// ============================================================================
module step_counter
    import count_scheduler_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic             en,
    input  wire logic             up,
    input  wire logic [CNT_W-1:0] value,
    output logic      [CNT_W-1:0] y
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            y <= '0;
        end else if (load) begin
            y <= clamp_val(value);
        end else if (en) begin
            if (up) begin
                y <= (y == CNT_W'(MAX_VAL)) ? '0 : y + CNT_W'(1);
            end else begin
                y <= (y == '0) ? CNT_W'(MAX_VAL) : y - CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/count_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : count_scheduler
// Brief   : Round-robin time-sharing of one mod-5 step counter by two requesters.
// Revision: 1.0 - initial release
// ============================================================================
module count_scheduler
    import count_scheduler_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         reset,
    count_scheduler_if.slave  bus
);

    state_t              r_state;
    logic                r_ptr;
    logic                r_sel;
    logic                r_dir;
    logic [CNT_W-1:0]    r_start;
    logic [STEP_W-1:0]   r_steps;
    logic [STEP_W-1:0]   r_remaining;
    logic [1:0]          r_gnt;
    logic [1:0]          r_done;
    logic                r_busy;
    logic [CNT_W-1:0]    r_result;
    logic                w_sel;
    logic [CNT_W-1:0]    w_y;

    // Pointer only breaks ties; a lone requester is always served.
    always_comb begin
        w_sel = bus.req[1];
        if (bus.req == 2'b11) begin
            w_sel = r_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_ptr       <= 1'b0;
            r_sel       <= 1'b0;
            r_dir       <= 1'b0;
            r_start     <= '0;
            r_steps     <= '0;
            r_remaining <= '0;
            r_gnt       <= 2'b00;
            r_done      <= 2'b00;
            r_busy      <= 1'b0;
            r_result    <= '0;
        end else begin
            r_done <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (|bus.req) begin
                        r_sel   <= w_sel;
                        r_dir   <= bus.dir[w_sel];
                        r_start <= w_sel ? bus.start1 : bus.start0;
                        r_steps <= w_sel ? bus.steps1 : bus.steps0;
                        r_gnt   <= w_sel ? 2'b10 : 2'b01;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_remaining <= r_steps;
                    if (r_steps == '0) begin
                        r_done  <= r_gnt;
                        r_state <= DONE;
                    end else begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_remaining <= r_remaining - STEP_W'(1);
                    if (r_remaining == STEP_W'(1)) begin
                        r_done  <= r_gnt;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_result <= w_y;
                    r_gnt    <= 2'b00;
                    r_busy   <= 1'b0;
                    r_ptr    <= ~r_sel;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    step_counter u_counter (
        .clk   (clk),
        .reset (reset),
        .load  (r_state == LOAD),
        .en    (r_state == RUN),
        .up    (r_dir),
        .value (r_start),
        .y     (w_y)
    );

    assign bus.gnt    = r_gnt;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.y      = w_y;
    // The final value is visible during DONE, before it is captured.
    assign bus.result = (r_state == DONE) ? w_y : r_result;

endmodule
`default_nettype wire

// File: tb/tb_count_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_count_scheduler
// Brief   : Directed, table-driven self-checking bench for count_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
module tb_count_scheduler;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    count_scheduler_if bus();

    count_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0] req;
        logic [1:0] dir;
        logic [2:0] start0;
        logic [2:0] start1;
        logic [3:0] steps0;
        logic [3:0] steps1;
        logic [1:0] exp_gnt;
        int         exp_lat;
        logic [2:0] exp_result;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    initial begin
        int lat;
        int exp_gnt_seq [7];
        int exp_y_seq [5];

        vecs[0] = '{2'b01, 2'b01, 3'd3, 3'd0, 4'd4,  4'd0,  2'b01, 5,  3'd2};
        vecs[1] = '{2'b10, 2'b00, 3'd0, 3'd1, 4'd0,  4'd3,  2'b10, 4,  3'd3};
        vecs[2] = '{2'b01, 2'b00, 3'd6, 3'd0, 4'd0,  4'd0,  2'b01, 1,  3'd4};
        vecs[3] = '{2'b10, 2'b10, 3'd0, 3'd7, 4'd0,  4'd15, 2'b10, 16, 3'd4};
        vecs[4] = '{2'b01, 2'b00, 3'd0, 3'd0, 4'd2,  4'd0,  2'b01, 3,  3'd3};
        vecs[5] = '{2'b10, 2'b10, 3'd0, 3'd2, 4'd0,  4'd5,  2'b10, 6,  3'd2};

        bus.req    = 2'b11;
        bus.dir    = 2'b00;
        bus.start0 = 3'd0;
        bus.start1 = 3'd0;
        bus.steps0 = 4'd0;
        bus.steps1 = 4'd0;

        // Reset held with both requesting
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_gnt",    bus.gnt,    0);
            chk("rst_busy",   bus.busy,   0);
            chk("rst_done",   bus.done,   0);
            chk("rst_y",      bus.y,      0);
            chk("rst_result", bus.result, 0);
        end

        // Round-robin with both requesting, zero-step operations
        exp_gnt_seq = '{1, 1, 0, 2, 2, 0, 1};
        reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("rr_gnt_%0d", i), bus.gnt, exp_gnt_seq[i]);
        end
        bus.req = 2'b00;
        tick();
        tick();
        chk("rr_idle_busy", bus.busy, 0);

        // Table vectors; operands scrambled and req dropped after grant
        for (int i = 0; i < 6; i++) begin
            bus.req    = vecs[i].req;
            bus.dir    = vecs[i].dir;
            bus.start0 = vecs[i].start0;
            bus.start1 = vecs[i].start1;
            bus.steps0 = vecs[i].steps0;
            bus.steps1 = vecs[i].steps1;
            tick();
            chk($sformatf("v%0d_gnt", i),  bus.gnt,  vecs[i].exp_gnt);
            chk($sformatf("v%0d_busy", i), bus.busy, 1);
            bus.req    = 2'b00;
            bus.dir    = ~bus.dir;
            bus.start0 = 3'd5;
            bus.start1 = 3'd5;
            bus.steps0 = 4'd1;
            bus.steps1 = 4'd1;
            lat = 0;
            do begin
                tick();
                lat++;
            end while (bus.done == 2'b00 && lat < 40);
            chk($sformatf("v%0d_lat", i),      lat,        vecs[i].exp_lat);
            chk($sformatf("v%0d_done", i),     bus.done,   vecs[i].exp_gnt);
            chk($sformatf("v%0d_dgnt", i),     bus.gnt,    vecs[i].exp_gnt);
            chk($sformatf("v%0d_y", i),        bus.y,      vecs[i].exp_result);
            chk($sformatf("v%0d_res_dn", i),   bus.result, vecs[i].exp_result);
            tick();
            chk($sformatf("v%0d_done_off", i), bus.done,   0);
            chk($sformatf("v%0d_gnt_off", i),  bus.gnt,    0);
            chk($sformatf("v%0d_busy_off", i), bus.busy,   0);
            chk($sformatf("v%0d_res_hold", i), bus.result, vecs[i].exp_result);
            chk($sformatf("v%0d_y_hold", i),   bus.y,      vecs[i].exp_result);
        end

        // Cycle-exact y trace: start 3, up, 4 steps
        exp_y_seq  = '{3, 4, 0, 1, 2};
        bus.req    = 2'b01;
        bus.dir    = 2'b01;
        bus.start0 = 3'd3;
        bus.steps0 = 4'd4;
        tick();
        bus.req = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("trace_y_%0d", i),    bus.y,    exp_y_seq[i]);
            chk($sformatf("trace_done_%0d", i), bus.done, (i == 4) ? 1 : 0);
        end
        tick();
        chk("trace_result", bus.result, 2);

        // Reset during RUN aborts without a done pulse
        bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        tick();
        tick();
        chk("abort_run_y", bus.y, 4);
        reset = 1'b0;
        tick();
        chk("abort_gnt",    bus.gnt,    0);
        chk("abort_busy",   bus.busy,   0);
        chk("abort_y",      bus.y,      0);
        chk("abort_done",   bus.done,   0);
        chk("abort_result", bus.result, 0);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("abort_post_done_%0d", i), bus.done, 0);
            chk($sformatf("abort_post_gnt_%0d", i),  bus.gnt,  0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
